seg_scan_mux: RTL and testbench

//   Parametrised N-digit multiplexed 7-segment scanner with a per-digit glyph frame buffer.

---
 rtl/seg_scan_mux.sv | 228 ++++++++++++++++++++++
 tb/tb_seg_scan_mux.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// ---------------------------------------------------------------------------
// seg_scan_mux
//   N-digit multiplexed 7-segment scanner with a per-digit glyph frame buffer.
//   Upstream logic writes glyphs into the buffer. This block handles the digit
//   scan, the anti-ghost dead time at the start of every digit slot, per-digit
//   blanking and blinking, and the output pin polarity.
//
// Optional feature macro: SEG_DIM_EN
//   When defined, an extra input dim_level[3:0] adds PWM brightness control.
//   Segments are lit only during the first (dim_level+1)/16 of the post-dead
//   part of each slot. dim_level is captured once per slot.
//   When undefined, the port does not exist and the block runs at full
//   brightness.
//
// Parameters
//   NUM_DIGITS   number of digits scanned (>= 2), digit 0 is rightmost
//   SCAN_DIV     clk cycles per digit slot (>= DEAD_CYC + 2)
//   DEAD_CYC     all-deselected cycles at the start of every slot
//   BLINK_DIV    clk cycles per blink half-period (>= 2)
//   SEG_ACT_LOW  1: seg_out/dp_out low-active, 0: high = lit
//   SEL_ACT_LOW  1: dig_sel low-active, 0: high = selected
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   glyph_wr     frame buffer write strobe
//   glyph_idx    digit index to write (indexes >= NUM_DIGITS are ignored)
//   glyph_data   {dp, G, F, E, D, C, B, A}, 1 = lit
//   blank_mask   bit i = 1 forces digit i dark
//   blink_mask   bit i = 1 makes digit i blink
//   dim_level    (SEG_DIM_EN only) brightness 0..15, 15 = full
//   seg_out      registered segments GFEDCBA
//   dp_out       registered decimal point
//   dig_sel      registered one-hot digit select
//   frame_tick   1-cycle pulse when the digit pointer wraps to 0
// ---------------------------------------------------------------------------
module seg_scan_mux #(
    parameter int NUM_DIGITS  = 8,
    parameter int SCAN_DIV    = 100000,
    parameter int DEAD_CYC    = 64,
    parameter int BLINK_DIV   = 25000000,
    parameter bit SEG_ACT_LOW = 1'b0,
    parameter bit SEL_ACT_LOW = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          glyph_wr,
    input  logic [$clog2(NUM_DIGITS)-1:0] glyph_idx,
    input  logic [7:0]                    glyph_data,
    input  logic [NUM_DIGITS-1:0]         blank_mask,
    input  logic [NUM_DIGITS-1:0]         blink_mask,
`ifdef SEG_DIM_EN
    input  logic [3:0]                    dim_level,
`endif
    output logic [6:0]                    seg_out,
    output logic                          dp_out,
    output logic [NUM_DIGITS-1:0]         dig_sel,
    output logic                          frame_tick
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int SLOT_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0]  DEAD_LIM   = SLOT_W'(DEAD_CYC);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [IDX_W-1:0]   PTR_LAST   = IDX_W'(NUM_DIGITS - 1);

    // Polarity is applied by XOR at the output register inputs so the pins
    // come straight from flops.
    localparam logic SEG_INV = SEG_ACT_LOW;
    localparam logic SEL_INV = SEL_ACT_LOW;

    // -----------------------------------------------------------------------
    // Frame buffer: one register per digit. An out-of-range index matches no
    // digit, so such a write is dropped without any extra logic.
    // -----------------------------------------------------------------------
    logic [7:0] glyph_arr [NUM_DIGITS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_mem
            logic [7:0] glyph_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    glyph_reg <= 8'h00;
                end else if (glyph_wr && (glyph_idx == IDX_W'(gi))) begin
                    glyph_reg <= glyph_data;
                end
            end

            assign glyph_arr[gi] = glyph_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Slot counter, digit pointer and frame tick
    // -----------------------------------------------------------------------
    logic [SLOT_W-1:0] slot_cnt_reg;
    logic [IDX_W-1:0]  ptr_reg;
    logic              tick_reg;
    logic              slot_wrap;
    logic              ptr_wrap;

    assign slot_wrap = (slot_cnt_reg == SLOT_LAST);
    assign ptr_wrap  = (ptr_reg == PTR_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_reg <= '0;
            ptr_reg      <= '0;
            tick_reg     <= 1'b0;
        end else begin
            // The tick is registered on the same edge that moves ptr to 0.
            tick_reg <= slot_wrap && ptr_wrap;
            if (slot_wrap) begin
                slot_cnt_reg <= '0;
                ptr_reg      <= ptr_wrap ? '0 : ptr_reg + 1'b1;
            end else begin
                slot_cnt_reg <= slot_cnt_reg + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Free-running blink timebase, unrelated to slot timing
    // -----------------------------------------------------------------------
    logic [BLINK_W-1:0] blink_cnt_reg;
    logic               phase_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
        end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg <= '0;
            phase_reg     <= ~phase_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Brightness gate
    // -----------------------------------------------------------------------
    logic dim_ok;

`ifdef SEG_DIM_EN
    localparam int CMP_W = SLOT_W + 5;

    logic [3:0]       dim_reg;
    logic [CMP_W-1:0] dim_lhs;
    logic [CMP_W-1:0] dim_rhs;

    // Captured on the slot wrap edge so the level is constant for the whole
    // slot that follows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dim_reg <= 4'hF;
        end else if (slot_wrap) begin
            dim_reg <= dim_level;
        end
    end

    // (slot_cnt - DEAD_CYC) * 16 < (dim + 1) * (SCAN_DIV - DEAD_CYC).
    // The subtraction wraps during the dead time, but the selector gates
    // the result off there anyway.
    assign dim_lhs = {5'b00000, slot_cnt_reg - DEAD_LIM} << 4;
    assign dim_rhs = CMP_W'({1'b0, dim_reg} + 5'd1) * CMP_W'(SCAN_DIV - DEAD_CYC);
    assign dim_ok  = (dim_lhs < dim_rhs);
`else
    assign dim_ok = 1'b1;
`endif

    // -----------------------------------------------------------------------
    // Output stage (one register stage)
    // -----------------------------------------------------------------------
    logic                  sel_on;
    logic [NUM_DIGITS-1:0] dig_sel_next;
    logic [7:0]            glyph_cur;
    logic                  lit_next;
    logic [6:0]            seg_next;
    logic                  dp_next;

    assign sel_on    = (slot_cnt_reg >= DEAD_LIM);
    assign glyph_cur = glyph_arr[ptr_reg];

    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
            assign dig_sel_next[gi] = sel_on && (ptr_reg == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        lit_next = sel_on && dim_ok && !blank_mask[ptr_reg]
                   && !(blink_mask[ptr_reg] && phase_reg);
        seg_next = 7'h00;
        dp_next  = 1'b0;
        if (lit_next) begin
            seg_next = glyph_cur[6:0];
            dp_next  = glyph_cur[7];
        end
    end

    logic [6:0]            seg_reg;
    logic                  dp_reg;
    logic [NUM_DIGITS-1:0] dig_sel_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_reg     <= {7{SEG_INV}};
            dp_reg      <= SEG_INV;
            dig_sel_reg <= {NUM_DIGITS{SEL_INV}};
        end else begin
            seg_reg     <= seg_next ^ {7{SEG_INV}};
            dp_reg      <= dp_next ^ SEG_INV;
            dig_sel_reg <= dig_sel_next ^ {NUM_DIGITS{SEL_INV}};
        end
    end

    assign seg_out    = seg_reg;
    assign dp_out     = dp_reg;
    assign dig_sel    = dig_sel_reg;
    assign frame_tick = tick_reg;

endmodule

// File: tb/tb_seg_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_mux
//   Two instances share one clock and one reset:
//     dut_a : 4 digits, active-high pins
//     dut_b : 5 digits, active-low pins (3-bit index, so indexes 5..7 can be
//             written and must be ignored)
//   The reference derives every expected output from the elapsed cycle count
//   since reset release (slot position, digit and blink phase by division and
//   modulo), plus model glyph arrays and the current mask inputs.
//   Define SEG_DIM_EN to also exercise the brightness input.
// ---------------------------------------------------------------------------
module tb_seg_scan_mux;

    localparam int SD = 8;
    localparam int DC = 2;
    localparam int BD = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic [3:0] dim_level;

    logic       wr_a;
    logic [1:0] idx_a;
    logic [7:0] data_a;
    logic [3:0] blank_a, blink_a;
    logic [6:0] seg_a;
    logic       dp_a;
    logic [3:0] sel_a;
    logic       tick_a;

    logic       wr_b;
    logic [2:0] idx_b;
    logic [7:0] data_b;
    logic [4:0] blank_b, blink_b;
    logic [6:0] seg_b;
    logic       dp_b;
    logic [4:0] sel_b;
    logic       tick_b;

    seg_scan_mux #(
        .NUM_DIGITS(4), .SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_DIV(BD),
        .SEG_ACT_LOW(1'b0), .SEL_ACT_LOW(1'b0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .glyph_wr(wr_a), .glyph_idx(idx_a), .glyph_data(data_a),
        .blank_mask(blank_a), .blink_mask(blink_a),
`ifdef SEG_DIM_EN
        .dim_level(dim_level),
`endif
        .seg_out(seg_a), .dp_out(dp_a), .dig_sel(sel_a), .frame_tick(tick_a)
    );

    seg_scan_mux #(
        .NUM_DIGITS(5), .SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_DIV(BD),
        .SEG_ACT_LOW(1'b1), .SEL_ACT_LOW(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .glyph_wr(wr_b), .glyph_idx(idx_b), .glyph_data(data_b),
        .blank_mask(blank_b), .blink_mask(blink_b),
`ifdef SEG_DIM_EN
        .dim_level(dim_level),
`endif
        .seg_out(seg_b), .dp_out(dp_b), .dig_sel(sel_b), .frame_tick(tick_b)
    );

    // Reference state
    logic [7:0] mem_a [4];
    logic [7:0] mem_b [5];
    int         cycles;
    int         dim_slot;
    logic [12:0] exp_a, obs_a;
    logic [13:0] exp_b, obs_b;

    int checks   = 0;
    int failures = 0;

    // Compute the expected outputs for the coming edge, apply pending writes
    // to the model, advance one clock and sample the DUTs.
    task automatic step();
        int pos, dga, dgb, ph;
        logic ok_dim;
        logic [3:0] sa;
        logic [4:0] sb;
        logic [7:0] ga, gb;
        pos = cycles % SD;
        ph  = (cycles / BD) % 2;
        dga = (cycles / SD) % 4;
        dgb = (cycles / SD) % 5;
        ok_dim = (pos >= DC) && (((pos - DC) * 16) < ((dim_slot + 1) * (SD - DC)));
        sa = '0; sb = '0; ga = '0; gb = '0;
        if (pos >= DC) begin
            sa[dga] = 1'b1;
            sb[dgb] = 1'b1;
        end
        if (ok_dim && !blank_a[dga] && !(blink_a[dga] && ph == 1)) ga = mem_a[dga];
        if (ok_dim && !blank_b[dgb] && !(blink_b[dgb] && ph == 1)) gb = mem_b[dgb];
        exp_a = {sa, ga[7], ga[6:0], (pos == SD - 1) && (dga == 3)};
        exp_b = {~sb, ~gb[7], ~gb[6:0], (pos == SD - 1) && (dgb == 4)};
        if (wr_a) mem_a[idx_a] = data_a;
        if (wr_b && idx_b < 3'd5) mem_b[idx_b] = data_b;
        if (pos == SD - 1) dim_slot = int'(dim_level);
        @(posedge clk);
        #1;
        cycles++;
        obs_a = {sel_a, dp_a, seg_a, tick_a};
        obs_b = {sel_b, dp_b, seg_b, tick_b};
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mem_a[i] = 8'h00;
        for (int i = 0; i < 5; i++) mem_b[i] = 8'h00;
        dim_slot = 15;
        cycles   = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        wr_a = 0; idx_a = 0; data_a = 0; blank_a = 0; blink_a = 0;
        wr_b = 0; idx_b = 0; data_b = 0; blank_b = 0; blink_b = 0;
        dim_level = 4'hF;
        #12;
        rst_n = 1'b0;
        model_clear();
        #1;
        obs_a = {sel_a, dp_a, seg_a, tick_a};
        obs_b = {sel_b, dp_b, seg_b, tick_b};
        checks++;
        if (obs_a !== 13'h0000) begin
            failures++;
            $display("FAIL reset_async_a got=%h want=%h", obs_a, 13'h0000);
        end
        checks++;
        if (obs_b !== 14'h3FFE) begin
            failures++;
            $display("FAIL reset_async_b got=%h want=%h", obs_b, 14'h3FFE);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs_a !== exp_a) begin
                failures++;
                $display("FAIL reset_seq_a cyc=%0d got=%h want=%h", cycles, obs_a, exp_a);
            end
            checks++;
            if (obs_b !== exp_b) begin
                failures++;
                $display("FAIL reset_seq_b cyc=%0d got=%h want=%h", cycles, obs_b, exp_b);
            end
        end
        checks++;
        if (sel_a !== 4'b0001) begin
            failures++;
            $display("FAIL reset_first_sel got=%b want=0001", sel_a);
        end
        $display("reset: released, first select after cycle %0d sel=%b", cycles, sel_a);
    endtask

    task automatic test_scan_order();
        logic [7:0] glyphs [4];
        int ticks, selected;
        glyphs = '{8'h06, 8'h5B, 8'h4F, 8'h66};
        for (int i = 0; i < 5; i++) begin
            wr_a = (i < 4); idx_a = 2'(i); data_a = glyphs[i % 4];
            wr_b = 1'b1; idx_b = 3'(i); data_b = (i < 4) ? glyphs[i] : 8'h80;
            step();
            checks++;
            if (obs_a !== exp_a) begin
                failures++;
                $display("FAIL scan_wr_a cyc=%0d got=%h want=%h", cycles, obs_a, exp_a);
            end
            checks++;
            if (obs_b !== exp_b) begin
                failures++;
                $display("FAIL scan_wr_b cyc=%0d got=%h want=%h", cycles, obs_b, exp_b);
            end
        end
        wr_a = 0; wr_b = 0;
        ticks = 0; selected = 0;
        for (int i = 0; i < 96; i++) begin
            if (i >= 32 || (cycles % 32) == 0) begin
                i = (i < 32) ? 32 : i;
            end
            step();
            if (i >= 32) begin
                if (tick_a) ticks++;
                if (sel_a != 0) selected++;
            end
            checks++;
            if (obs_a !== exp_a) begin
                failures++;
                $display("FAIL scan_a cyc=%0d got=%h want=%h", cycles, obs_a, exp_a);
            end
            checks++;
            if (obs_b !== exp_b) begin
                failures++;
                $display("FAIL scan_b cyc=%0d got=%h want=%h", cycles, obs_b, exp_b);
            end
        end
        checks++;
        if (ticks !== 2 || selected !== 48) begin
            failures++;
            $display("FAIL scan_counts ticks=%0d sel_cycles=%0d want ticks=2 sel_cycles=48", ticks, selected);
        end
        $display("scan: 64 cycles, frame ticks=%0d selected cycles=%0d", ticks, selected);
    endtask

    task automatic test_write_hazard();
        for (int i = 0; i < 40 && (cycles % 32) != 3; i++) begin
            step();
            checks++;
            if (obs_a !== exp_a) begin
                failures++;
                $display("FAIL hazard_align cyc=%0d got=%h want=%h", cycles, obs_a, exp_a);
            end
        end
        wr_a = 1'b1; idx_a = 2'd0; data_a = 8'h3F;
        step();
        wr_a = 1'b0;
        checks++;
        if (obs_a !== exp_a || sel_a !== 4'b0001) begin
            failures++;
            $display("FAIL hazard_wr_edge got=%h want=%h", obs_a, exp_a);
        end
        step();
        checks++;
        if (seg_a !== 7'h3F || sel_a !== 4'b0001) begin
            failures++;
            $display("FAIL hazard_visible seg=%h sel=%b want seg=3f sel=0001", seg_a, sel_a);
        end
        // Out-of-range writes on the 5-digit instance
        for (int i = 5; i < 8; i++) begin
            wr_b = 1'b1; idx_b = 3'(i); data_b = 8'hFF;
            step();
        end
        wr_b = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if (obs_b !== exp_b) begin
                failures++;
                $display("FAIL hazard_oob_b cyc=%0d got=%h want=%h", cycles, obs_b, exp_b);
            end
        end
        $display("hazard: live write digit0 seg=%h, idx 5..7 writes on 5-digit unit", seg_a);
    endtask

    task automatic test_polarity();
        for (int i = 0; i < 50 && (cycles % 40) != 3; i++) step();
        checks++;
        if (seg_b !== 7'h79 || sel_b !== 5'b11110 || dp_b !== 1'b1) begin
            failures++;
            $display("FAIL polarity seg=%h sel=%b dp=%b want seg=79 sel=11110 dp=1", seg_b, sel_b, dp_b);
        end
        $display("polarity: seg=%h sel=%b dp=%b", seg_b, sel_b, dp_b);
    endtask

    task automatic test_blank_blink();
        int lit2, dark2, lit1;
        blank_a = 4'b0010; blink_a = 4'b0100;
        blank_b = 5'b10000; blink_b = 5'b00001;
        lit2 = 0; dark2 = 0; lit1 = 0;
        for (int i = 0; i < 300; i++) begin
            if (i < 150 && (cycles % 128) == 0) i = 150;
            if (i >= 278) break;
            step();
            if (i >= 150) begin
                if (sel_a == 4'b0100 && seg_a != 0) lit2++;
                if (sel_a == 4'b0100 && seg_a == 0) dark2++;
                if (sel_a == 4'b0010 && seg_a != 0) lit1++;
            end
            checks++;
            if (obs_a !== exp_a) begin
                failures++;
                $display("FAIL blink_a cyc=%0d got=%h want=%h", cycles, obs_a, exp_a);
            end
            checks++;
            if (obs_b !== exp_b) begin
                failures++;
                $display("FAIL blink_b cyc=%0d got=%h want=%h", cycles, obs_b, exp_b);
            end
        end
        checks++;
        if (lit2 !== 12 || dark2 !== 12 || lit1 !== 0) begin
            failures++;
            $display("FAIL blink_counts lit2=%0d dark2=%0d lit1=%0d want 12 12 0", lit2, dark2, lit1);
        end
        $display("blank/blink: digit2 lit=%0d dark=%0d, digit1 lit=%0d", lit2, dark2, lit1);
        blank_a = 0; blink_a = 0; blank_b = 0; blink_b = 0;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 1500; i++) begin
            wr_a = ($urandom_range(0, 3) == 0); idx_a = 2'($urandom); data_a = 8'($urandom);
            wr_b = ($urandom_range(0, 3) == 0); idx_b = 3'($urandom); data_b = 8'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                blank_a = 4'($urandom); blink_a = 4'($urandom);
                blank_b = 5'($urandom); blink_b = 5'($urandom);
            end
            step();
            checks++;
            if (obs_a !== exp_a) begin
                failures++; errs++;
                $display("FAIL random_a cyc=%0d got=%h want=%h", cycles, obs_a, exp_a);
            end
            checks++;
            if (obs_b !== exp_b) begin
                failures++; errs++;
                $display("FAIL random_b cyc=%0d got=%h want=%h", cycles, obs_b, exp_b);
            end
        end
        wr_a = 0; wr_b = 0;
        blank_a = 0; blink_a = 0; blank_b = 0; blink_b = 0;
        $display("random: 1500 cycles, errors=%0d", errs);
    endtask

    task automatic test_reset_mid();
        #3;
        rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if ({sel_a, dp_a, seg_a, tick_a} !== 13'h0000) begin
            failures++;
            $display("FAIL reset_mid_a got=%b%b%h%b", sel_a, dp_a, seg_a, tick_a);
        end
        checks++;
        if ({sel_b, dp_b, seg_b, tick_b} !== 14'h3FFE) begin
            failures++;
            $display("FAIL reset_mid_b got=%b%b%h%b", sel_b, dp_b, seg_b, tick_b);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if (obs_a !== exp_a) begin
                failures++;
                $display("FAIL reset_mid_seq_a cyc=%0d got=%h want=%h", cycles, obs_a, exp_a);
            end
            checks++;
            if (obs_b !== exp_b) begin
                failures++;
                $display("FAIL reset_mid_seq_b cyc=%0d got=%h want=%h", cycles, obs_b, exp_b);
            end
        end
        $display("reset mid-run: buffers cleared, scan restarted");
    endtask

`ifdef SEG_DIM_EN
    task automatic test_dim();
        int lit;
        logic [3:0] levels [2];
        int want [2];
        levels = '{4'd7, 4'd15};
        want   = '{3, 6};
        for (int i = 0; i < 4; i++) begin
            wr_a = 1'b1; idx_a = 2'(i); data_a = 8'h7F;
            step();
        end
        wr_a = 1'b0;
        for (int k = 0; k < 2; k++) begin
            dim_level = levels[k];
            step();
            for (int i = 0; i < 10 && (cycles % SD) != 0; i++) step();
            lit = 0;
            for (int i = 0; i < SD; i++) begin
                step();
                if (seg_a != 0) lit++;
                checks++;
                if (obs_a !== exp_a) begin
                    failures++;
                    $display("FAIL dim_a cyc=%0d got=%h want=%h", cycles, obs_a, exp_a);
                end
            end
            checks++;
            if (lit !== want[k]) begin
                failures++;
                $display("FAIL dim_count level=%0d lit=%0d want=%0d", levels[k], lit, want[k]);
            end
            $display("dim: level=%0d lit cycles=%0d", levels[k], lit);
        end
        dim_level = 4'hF;
    endtask
`endif

    initial begin
        test_reset();
        test_scan_order();
        test_write_hazard();
        test_polarity();
        test_blank_blink();
        test_random();
        test_reset_mid();
`ifdef SEG_DIM_EN
        test_dim();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
